clock_divider_bank: RTL and testbench
=====================================

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_W, 27, divisor width in bits.
- RST_DIV, 2**DIV_W-1, active divisor value loaded into every channel at reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_in, input, 1, sole clock.
- rst, input, 1, reset; asynchronous, active-low.
- ch_en, input, NUM_CH, per-channel count enable.
- div_val, input, NUM_CH*DIV_W, per-channel divisor; channel i uses bits [i*DIV_W +: DIV_W].
- div_load, input, NUM_CH, one-cycle strobe that captures div_val[i] into the shadow register of channel i.
- sync_clr, input, 1, synchronous restart of all channels.
- tick, output, NUM_CH, one-cycle enable pulse per channel period.
- sq, output, NUM_CH, square wave per channel.

Function
REQ-003 Each channel SHALL hold a DIV_W-bit counter cnt, an active divisor act, and a shadow divisor shd.
REQ-004 With ch_en[i]=1, cnt SHALL increment each clk_in edge and wrap to 0 on the cycle after cnt==act, giving a period of act+1 cycles.
REQ-005 tick[i] SHALL be registered and SHALL be high for exactly one cycle, in the cycle after the edge at which cnt==act; tick latency from the count match SHALL be 1 cycle.
REQ-006 sq[i] SHALL toggle on every wrap of channel i, giving a period of 2*(act+1) cycles at 50% duty.
REQ-007 act=0 SHALL produce tick[i] high continuously and sq[i] toggling every cycle.
REQ-008 With ch_en[i]=0, cnt and sq[i] SHALL hold their values and tick[i] SHALL be 0; counting SHALL resume from the held cnt when ch_en[i] returns to 1.
REQ-009 div_load[i]=1 SHALL capture div_val[i] into shd.
REQ-010 shd SHALL copy into act only at a wrap, or immediately when ch_en[i]=0, so that no period is ever truncated.
REQ-011 If div_load[i] coincides with a wrap, the newly loaded value SHALL become act at that wrap.
REQ-012 sync_clr=1 SHALL, on the next edge, set every cnt to 0, every sq to 0, every tick to 0, and copy every shd into act.
REQ-013 sync_clr SHALL take priority over ch_en, wrap and div_load; a div_load coinciding with sync_clr SHALL be captured and applied at the same edge.
REQ-014 Channels SHALL be fully independent except through sync_clr.

Reset
REQ-015 While rst=0, for all channels: cnt=0, act=RST_DIV, shd=RST_DIV, tick=0, sq=0 (and blink=0 when present), with no dependence on clk_in.
REQ-016 Reset deassertion SHALL be synchronised to clk_in with a 2-flop synchroniser; counting SHALL begin on the second clk_in edge after rst rises.
REQ-017 Assertion of rst mid-period SHALL abort the period immediately, with no residual tick.

Configuration
REQ-018 Macro CLKDIV_BLINK_EN SHALL add two ports:
- blink_mask, input, NUM_CH.
- blink, output, NUM_CH, registered.
The output SHALL be blink[i] = blink_mask[i] ? (sq[i] & sq[NUM_CH-1]) : sq[i], with 1-cycle latency from sq.
REQ-019 Without CLKDIV_BLINK_EN, the blink_mask and blink ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-020 Package clkdiv_pkg SHALL hold the DIV_W default, the NUM_CH limit, and a per-channel state struct type containing cnt, act and shd.
REQ-021 Sub-module clkdiv_channel SHALL implement one channel (REQ-003 to REQ-011); clock_divider_bank SHALL generate NUM_CH instances of it, plus the reset synchroniser, the sync_clr fan-out and the optional blink logic.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- Divisor 3: load div_val=3 on channel 0 with ch_en=1 -> tick[0] every 4 cycles and sq[0] period 8 cycles.
- Edge divisor: div_val=0 on channel 1 -> tick[1] constant 1 and sq[1] toggling every cycle.
- Deferred reload: load 9 while act=3, mid-period at cnt=1 -> the current period completes in 4 cycles, then the period becomes 10 cycles.
- Hold: ch_en[2]=0 for 5 cycles at cnt=2 -> tick[2]=0, cnt holds at 2, and the next tick arrives 2 enabled cycles after re-enable.
- Simultaneous events: sync_clr together with div_load (value 5) on all channels -> all cnt=0, sq=0, and act=5 on the next edge.
- Mid-period reset: rst low at cnt=7 of act=15 -> outputs 0 immediately, with no tick after release until 16 enabled cycles have passed.
- Blink (CLKDIV_BLINK_EN only): blink_mask=4'b0001 -> blink[0] equals sq[0]&sq[3] delayed by one cycle, and blink[1] equals sq[1] delayed by one cycle.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider bank.
//
// Holds the default divisor width, the channel-count limit and the per-channel
// state record. The record is sized to DIV_W_MAX so a single type serves every
// DIV_W instantiation; channels keep the bits above DIV_W at zero.
package clkdiv_pkg;

    localparam int unsigned DIV_W_DEF  = 27;
    localparam int unsigned NUM_CH_MAX = 16;
    localparam int unsigned DIV_W_MAX  = 32;

    typedef logic [DIV_W_MAX-1:0] div_word_t;

    typedef struct packed {
        div_word_t cnt;  // position within the current period
        div_word_t act;  // divisor in force for the current period
        div_word_t shd;  // divisor waiting to take effect at the next wrap
    } ch_state_t;

    // Mask selecting the low w bits of a div_word_t.
    function automatic div_word_t div_mask(input int unsigned w);
        if (w >= DIV_W_MAX) begin
            return '1;
        end
        return (div_word_t'(1) << w) - div_word_t'(1);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active divisor and shadow divisor.
//
// Ports:
//   clk_in   - clock
//   rst      - asynchronous active-low reset (already synchronised on release)
//   en       - count enable; while low the count and square wave hold
//   clr      - synchronous restart; beats en, wrap and div_load
//   div_load - strobe capturing div_val into the shadow divisor
//   div_val  - divisor to capture
//   tick     - registered one-cycle pulse per period
//   sq       - square wave, toggles on every wrap
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned      DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] RST_DIV = {DIV_W{1'b1}}
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick,
    output logic             sq
);

    localparam div_word_t CNT_MASK = div_mask(DIV_W);
    localparam div_word_t RST_WORD = div_word_t'(RST_DIV);

    ch_state_t st_q, st_d;
    logic      tick_q, tick_d;
    logic      sq_q, sq_d;
    div_word_t shd_nx;

    always_comb begin
        // A load in the same cycle as a divisor copy is forwarded, so a
        // coinciding wrap or clear picks up the new value immediately.
        shd_nx   = div_load ? div_word_t'(div_val) : st_q.shd;
        st_d     = st_q;
        st_d.shd = shd_nx;
        tick_d   = 1'b0;
        sq_d     = sq_q;
        if (clr) begin
            st_d.cnt = '0;
            st_d.act = shd_nx;
            sq_d     = 1'b0;
        end else if (!en) begin
            // Idle channel: nothing to truncate, so adopt the new divisor now.
            st_d.act = shd_nx;
        end else if (st_q.cnt == st_q.act) begin
            st_d.cnt = '0;
            st_d.act = shd_nx;
            tick_d   = 1'b1;
            sq_d     = ~sq_q;
        end else begin
            st_d.cnt = (st_q.cnt + div_word_t'(1)) & CNT_MASK;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            st_q.cnt <= '0;
            st_q.act <= RST_WORD;
            st_q.shd <= RST_WORD;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
        end else begin
            st_q   <= st_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable clock-enable dividers.
//
// Each channel produces a one-cycle tick every act+1 cycles and a 50% square
// wave of period 2*(act+1). New divisors are shadowed and only take effect at
// a period boundary, when the channel is idle, or on sync_clr.
//
// Ports:
//   clk_in     - sole clock
//   rst        - asynchronous active-low reset; release synchronised (2 flops)
//   ch_en      - per-channel count enable
//   div_val    - per-channel divisor, channel i at [i*DIV_W +: DIV_W]
//   div_load   - per-channel strobe capturing div_val into the shadow divisor
//   sync_clr   - synchronous restart of every channel
//   tick       - per-channel period pulse
//   sq         - per-channel square wave
//   blink_mask - (CLKDIV_BLINK_EN) selects sq[i] & sq[NUM_CH-1] for blink[i]
//   blink      - (CLKDIV_BLINK_EN) registered blink output
//
// Build option: define CLKDIV_BLINK_EN to add blink_mask/blink.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned      NUM_CH  = 4,
    parameter int unsigned      DIV_W   = DIV_W_DEF,
    parameter logic [DIV_W-1:0] RST_DIV = {DIV_W{1'b1}}
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync_clr,
`ifdef CLKDIV_BLINK_EN
    input  logic [NUM_CH-1:0]       blink_mask,
    output logic [NUM_CH-1:0]       blink,
`endif
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq
);

    // Reset asserts asynchronously through both stages and releases two edges
    // later, so channels leave reset cleanly aligned to clk_in.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk_in   (clk_in),
            .rst      (rst_sync_q),
            .en       (ch_en[i]),
            .clr      (sync_clr),
            .div_load (div_load[i]),
            .div_val  (div_val[i*DIV_W +: DIV_W]),
            .tick     (tick[i]),
            .sq       (sq[i])
        );
    end

`ifdef CLKDIV_BLINK_EN
    logic [NUM_CH-1:0] blink_q;

    // Masked channels blink only while the last channel's square wave is high.
    always_ff @(posedge clk_in or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            blink_q <= '0;
        end else begin
            blink_q <= (sq & ~blink_mask) | (sq & blink_mask & {NUM_CH{sq[NUM_CH-1]}});
        end
    end

    assign blink = blink_q;
`endif

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_clock_divider_bank;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam logic [DW-1:0] RDIV = 8'd15;
    localparam int MODW = 256;

    logic              clk_in = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_en;
    logic [NCH*DW-1:0] div_val;
    logic [NCH-1:0]    div_load;
    logic              sync_clr;
    logic [NCH-1:0]    blink_mask;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    sq;
`ifdef CLKDIV_BLINK_EN
    logic [NCH-1:0]    blink;
`endif

    clock_divider_bank #(
        .NUM_CH  (NCH),
        .DIV_W   (DW),
        .RST_DIV (RDIV)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .ch_en      (ch_en),
        .div_val    (div_val),
        .div_load   (div_load),
        .sync_clr   (sync_clr),
`ifdef CLKDIV_BLINK_EN
        .blink_mask (blink_mask),
        .blink      (blink),
`endif
        .tick       (tick),
        .sq         (sq)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-channel position, divisors and outputs.
    int             m_cnt [NCH];
    int             m_act [NCH];
    int             m_shd [NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_sq;
    logic [NCH-1:0] m_blink;
    int             rel_edges;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_act[i] = int'(RDIV);
            m_shd[i] = int'(RDIV);
        end
        m_tick    = '0;
        m_sq      = '0;
        m_blink   = '0;
        rel_edges = 0;
    endfunction

    // One rising edge of the model, using the inputs currently applied.
    function automatic void model_edge();
        logic [NCH-1:0] old_sq;
        int             new_shd;
        if (!rst) return;
        // Two edges of reset synchronisation before any channel moves.
        if (rel_edges < 2) begin
            rel_edges++;
            return;
        end
        old_sq = m_sq;
        for (int i = 0; i < NCH; i++) begin
            m_blink[i] = blink_mask[i] ? (old_sq[i] & old_sq[NCH-1]) : old_sq[i];
        end
        for (int i = 0; i < NCH; i++) begin
            new_shd   = div_load[i] ? int'(div_val[i*DW +: DW]) : m_shd[i];
            m_tick[i] = 1'b0;
            if (sync_clr) begin
                m_cnt[i] = 0;
                m_sq[i]  = 1'b0;
                m_act[i] = new_shd;
            end else if (!ch_en[i]) begin
                m_act[i] = new_shd;
            end else if (m_cnt[i] == m_act[i]) begin
                m_cnt[i]  = 0;
                m_tick[i] = 1'b1;
                m_sq[i]   = ~m_sq[i];
                m_act[i]  = new_shd;
            end else begin
                m_cnt[i] = (m_cnt[i] + 1) % MODW;
            end
            m_shd[i] = new_shd;
        end
    endfunction

    task automatic step_cycle();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_eq("tick", 32'(tick), 32'(m_tick));
        check_eq("sq", 32'(sq), 32'(m_sq));
`ifdef CLKDIV_BLINK_EN
        check_eq("blink", 32'(blink), 32'(m_blink));
`endif
    endtask

    task automatic cycles_to_tick(input int ch, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            step_cycle();
            if (tick[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic set_div(input int ch, input int v);
        div_val[ch*DW +: DW] = DW'(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        rst        = 1'b0;
        ch_en      = '0;
        div_val    = '0;
        div_load   = '0;
        sync_clr   = 1'b0;
        blink_mask = '0;
        model_reset();
        repeat (3) step_cycle();
        check_eq("reset tick", 32'(tick), 32'h0);
        check_eq("reset sq", 32'(sq), 32'h0);

        // Startup: 2 sync edges, then a full RST_DIV+1 period.
        rst   = 1'b1;
        ch_en = '1;
        cycles_to_tick(0, 40, n);
        check_eq("startup latency", 32'(n), 32'd18);

        // Divisor 3 on channel 0.
        set_div(0, 3);
        div_load = 4'b0001;
        sync_clr = 1'b1;
        step_cycle();
        div_load = '0;
        sync_clr = 1'b0;
        cycles_to_tick(0, 20, n);
        check_eq("div3 first period", 32'(n), 32'd4);
        cycles_to_tick(0, 20, n);
        check_eq("div3 second period", 32'(n), 32'd4);
        repeat (12) step_cycle();

        // Divisor 0 on channel 1: continuous tick.
        set_div(1, 0);
        div_load = 4'b0010;
        sync_clr = 1'b1;
        step_cycle();
        div_load = '0;
        sync_clr = 1'b0;
        cycles_to_tick(1, 5, n);
        check_eq("div0 first tick", 32'(n), 32'd1);
        k = 0;
        repeat (6) begin
            step_cycle();
            if (tick[1]) k++;
        end
        check_eq("div0 tick run", 32'(k), 32'd6);

        // Deferred reload on channel 0: load 9 at cnt=1 of act=3.
        sync_clr = 1'b1;
        step_cycle();
        sync_clr = 1'b0;
        step_cycle();
        set_div(0, 9);
        div_load = 4'b0001;
        step_cycle();
        div_load = '0;
        cycles_to_tick(0, 20, n);
        check_eq("reload old period ends", 32'(n), 32'd2);
        cycles_to_tick(0, 20, n);
        check_eq("reload new period", 32'(n), 32'd10);
        cycles_to_tick(0, 20, n);
        check_eq("reload new period again", 32'(n), 32'd10);

        // Hold channel 2 at cnt=2 of act=3.
        set_div(2, 3);
        div_load = 4'b0100;
        sync_clr = 1'b1;
        step_cycle();
        div_load = '0;
        sync_clr = 1'b0;
        repeat (2) step_cycle();
        ch_en[2] = 1'b0;
        k = 0;
        repeat (5) begin
            step_cycle();
            if (tick[2]) k++;
        end
        check_eq("hold no tick", 32'(k), 32'd0);
        ch_en[2] = 1'b1;
        cycles_to_tick(2, 10, n);
        check_eq("hold resume", 32'(n), 32'd2);

        // sync_clr with div_load=5 on every channel.
        for (int i = 0; i < NCH; i++) set_div(i, 5);
        div_load = '1;
        sync_clr = 1'b1;
        step_cycle();
        div_load = '0;
        sync_clr = 1'b0;
        check_eq("clr sq", 32'(sq), 32'h0);
        check_eq("clr tick", 32'(tick), 32'h0);
        cycles_to_tick(3, 20, n);
        check_eq("clr load period", 32'(n), 32'd6);

        // Mid-period reset at cnt=7 of act=15 on channel 3.
        set_div(3, 15);
        div_load = 4'b1000;
        sync_clr = 1'b1;
        step_cycle();
        div_load = '0;
        sync_clr = 1'b0;
        repeat (7) step_cycle();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("async rst tick", 32'(tick), 32'h0);
        check_eq("async rst sq", 32'(sq), 32'h0);
        @(negedge clk_in);
        repeat (2) step_cycle();
        rst = 1'b1;
        cycles_to_tick(3, 40, n);
        check_eq("post reset first tick", 32'(n), 32'd18);

`ifdef CLKDIV_BLINK_EN
        blink_mask = 4'b0001;
        set_div(0, 2);
        set_div(1, 4);
        set_div(3, 1);
        div_load = 4'b1011;
        sync_clr = 1'b1;
        step_cycle();
        div_load = '0;
        sync_clr = 1'b0;
        repeat (30) step_cycle();
`endif

        // Randomized traffic.
        repeat (600) begin
            for (int i = 0; i < NCH; i++) begin
                ch_en[i]    = ($urandom_range(0, 99) < 85);
                div_load[i] = ($urandom_range(0, 9) == 0);
                set_div(i, int'($urandom_range(0, 12)));
            end
            sync_clr   = ($urandom_range(0, 49) == 0);
            blink_mask = NCH'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
